// File: rtl/seq_divider_8_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The requester drives operands and start; the divider returns results and status.
interface seq_divider_8_if #(
  parameter int N = 8
);
  logic           start;
  logic [2*N-1:0] a;
  logic [N-1:0]   b;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;
  logic           dbz;

  modport master (
    output start, a, b,
    input  q, r, busy, done, dbz
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, dbz
  );
endinterface

// File: rtl/seq_divider_8.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Results are held from the DONE cycle until the next accepted start.
module seq_divider_8 #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_divider_8_if.slave dif
);

  localparam int             CW   = $clog2(2*N) + 1;
  localparam logic [CW-1:0]  LAST = CW'(2*N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit out of the MSB and one quotient bit in at the LSB.
  logic [2*N-1:0] dvd;
  logic [N-1:0]   dvs;
  logic [N-1:0]   pr;
  logic [CW-1:0]  cnt;

  logic [2*N-1:0] q_reg;
  logic [N-1:0]   r_reg;
  logic           dbz_reg;

  logic [N:0]     pr_shift;
  logic [N-1:0]   pr_diff;
  logic [N-1:0]   pr_next;
  logic           qbit;
  logic           last_step;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pr_shift   = {pr, dvd[2*N-1]};
    qbit       = (pr_shift >= {1'b0, dvs});
    // Result is below the divisor whenever it is kept, so N bits suffice.
    pr_diff    = pr_shift[N-1:0] - dvs;
    pr_next    = qbit ? pr_diff : pr_shift[N-1:0];
    last_step  = (cnt == LAST);
    state_next = state;

    case (state)
      IDLE: begin
        if (dif.start) begin
          state_next = (dif.b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd     <= '0;
      dvs     <= '0;
      pr      <= '0;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.start) begin
            if (dif.b == '0) begin
              q_reg   <= '1;
              r_reg   <= dif.a[N-1:0];
              dbz_reg <= 1'b1;
            end else begin
              dvd <= dif.a;
              dvs <= dif.b;
              pr  <= '0;
              cnt <= '0;
            end
          end
        end
        RUN: begin
          dvd <= {dvd[2*N-2:0], qbit};
          pr  <= pr_next;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            q_reg   <= {dvd[2*N-2:0], qbit};
            r_reg   <= pr_next;
            dbz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dif.q    = q_reg;
  assign dif.r    = r_reg;
  assign dif.dbz  = dbz_reg;
  assign dif.busy = (state != IDLE);
  assign dif.done = (state == DONE);

endmodule

// File: tb/tb_seq_divider_8.sv
// Scoreboard bench for seq_divider_8: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_seq_divider_8;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_divider_8_if #(.N(N)) dif ();

  seq_divider_8 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  typedef struct packed {
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dbz;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc = 0;
  longint last_done = -1;
  bit     spacing_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dif.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("q", 32'(dif.q), 32'(e.q));
          check("r", 32'(dif.r), 32'(e.r));
          check("dbz", 32'(dif.dbz), 32'(e.dbz));
        end
        if (spacing_on && last_done >= 0) check("done_spacing", 32'(cyc - last_done), 32'd18);
        last_done = cyc;
      end
    end
  end

  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a[N-1:0]; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = N'(a % b); e.dbz = 1'b0;
    end
    return e;
  endfunction

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic wait_idle();
    int k = 0;
    while (dif.busy !== 1'b0 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic launch(input logic [2*N-1:0] a, input logic [N-1:0] b);
    wait_idle();
    dif.a = a; dif.b = b; dif.start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  // k0 = edges already elapsed since acceptance, all of them with busy high.
  task automatic finish(input int k0, input bit zero_div);
    int k = k0;
    int bc = k0;
    forever begin
      if (dif.busy === 1'b1) bc++;
      if (dif.done === 1'b1 || k >= 40) break;
      @(posedge clk); #1; k++;
    end
    check("latency", 32'(k), zero_div ? 32'd0 : 32'(2*N));
    check("busy_cycles", 32'(bc), zero_div ? 32'd1 : 32'(2*N + 1));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(dif.done), 32'd0);
    check("busy_after", 32'(dif.busy), 32'd0);
  endtask

  task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
    launch(a, b);
    finish(0, b == '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_q"}, 32'(dif.q), 32'd0);
    check({tag, "_r"}, 32'(dif.r), 32'd0);
    check({tag, "_busy"}, 32'(dif.busy), 32'd0);
    check({tag, "_done"}, 32'(dif.done), 32'd0);
    check({tag, "_dbz"}, 32'(dif.dbz), 32'd0);
  endtask

  initial begin
    int k;
    logic [2*N-1:0] ra;
    logic [N-1:0]   rb;

    dif.start = 1'b0; dif.a = '0; dif.b = '0;

    // Reset state
    @(posedge clk); #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, including operands straight from the multiplier
    run_op(16'd1000, 8'd7);
    run_op(16'hFFFF, 8'hFF);
    run_op(16'd5, 8'd9);
    run_op(16'hFE01, 8'd255);

    // Divide by zero, then a valid op clears dbz
    run_op(16'h1234, 8'd0);
    check("dbz_held_idle", 32'(dif.dbz), 32'd1);
    run_op(16'd200, 8'd9);

    // Start during RUN is ignored; the original operation completes
    launch(16'd1000, 8'd7);
    repeat (5) begin @(posedge clk); #1; end
    dif.a = 16'd99; dif.b = 8'd3; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    finish(6, 1'b0);
    run_op(16'd99, 8'd3);

    // Asynchronous reset mid-operation discards the result
    launch(16'd40000, 8'd123);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    sb.delete();
    repeat (2) begin @(posedge clk); #1; end
    check("midreset_hold_busy", 32'(dif.busy), 32'd0);
    rst_n = 1'b1;
    run_op(16'd40000, 8'd123);

    // Random operands with start held high: back-to-back issue
    wait_idle();
    spacing_on = 1'b1;
    last_done = -1;
    dif.start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      dif.a = ra; dif.b = rb;
      sb.push_back(model(ra, rb));
      @(posedge clk); #1;
      check("accept", 32'(dif.busy), 32'd1);
      if (i == 999) dif.start = 1'b0;
      else wait_idle();
    end
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    spacing_on = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_8.md
Name: seq_divider_8

Overview:
- Iterative restoring divider; the inverse operation of the team's 8x8 array multiplier.
- Takes a 2N-bit dividend (for example, a multiplier product) and an N-bit divisor.
- Returns a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit, behind a start/busy/done handshake.

Parameters:
- N, 8, divisor and remainder width; dividend and quotient are 2*N bits.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled on a rising clk edge, accepted only in IDLE.
- a  input  2*N  dividend; captured on the accepting edge.
- b  input  N  divisor; captured on the accepting edge.
- q  output  2*N  quotient; valid from the edge that raises done, held until the next accepted start.
- r  output  N  remainder; same validity as q.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse: results valid.
- dbz  output  1  divide-by-zero flag; same validity as q.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; q=0, r=0, busy=0, done=0, dbz=0; internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge T, b!=0:
  - Capture a into the dividend shift register and b into the divisor register.
  - Clear the partial remainder (N+1 bits) and the iteration counter (log2(2N)+1 bits).
  - Go to RUN.
- IDLE, start=1 at edge T, b==0:
  - Go directly to DONE.
  - q = all ones, r = a[N-1:0], dbz = 1.
  - No iterations are run.
- RUN: each edge performs one restoring step, MSB first.
  - pr' = {pr[N-1:0], dividend MSB}; shift the dividend left by 1.
  - If pr' >= {1'b0, b}: pr = pr' - b and the quotient bit is 1. Otherwise pr = pr' and the quotient bit is 0.
  - Shift the quotient bit into the quotient register LSB.
  - Compare at N+1 bits so there is no overflow; remainder is always < b and fits in N bits.
- After the 2N-th step (edge T+2N):
  - State=DONE; q, r and dbz=0 are loaded; done=1.
- Latency: start accepted at edge T; done is high in the cycle after edge T+2N. For N=8, that is 16 cycles. For divide-by-zero, done is high after edge T+1.
- DONE: exactly one cycle, then IDLE at the next edge; done=0, busy=0.
- q, r and dbz hold their values through IDLE until the next accepted start loads new results.
  - They are not cleared on start; they update only on entry to DONE.
- start while busy (RUN or DONE): ignored. Operands are not re-captured and no queueing occurs.
- start may be held high continuously: a new operation is accepted at each IDLE edge, giving an issue interval of 2N+2 cycles.
- a/b changes during RUN have no effect (captured copy is used).
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded, done does not pulse, and no stale result remains.
- Invariant for b!=0: a == q*b + r and r < b. All arithmetic is unsigned.

Test Plan:
- Reset, then a=16'd1000, b=8'd7, start pulse -> done pulses in the 16th cycle after acceptance; q=16'd142, r=8'd6, dbz=0; busy high for 17 cycles.
- a=16'hFFFF, b=8'hFF -> q=16'h0101, r=8'h00. Then a=16'd5, b=8'd9 -> q=0, r=5. Then a=16'hFE01 (255*255 from the multiplier), b=8'd255 -> q=16'd255, r=0.
- a=16'h1234, b=0 -> done in the first cycle after acceptance; dbz=1, q=16'hFFFF, r=8'h34; next valid op clears dbz.
- Start pulse at cycle 5 of RUN with a=16'd99, b=8'd3 -> ignored; the original operation completes with the original values; a new start in IDLE then yields q=33, r=0.
- Drop rst_n at cycle 8 of RUN -> q, r, busy, done and dbz go to 0 asynchronously; no done pulse; a fresh start after release computes correctly.
- Random 1000 operands with b!=0 and start held high -> each result satisfies q*b+r==a and r<b; done spacing is 18 cycles.
